ysyx_22040750_muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It executes the full RV64M/RV32M set (including W-suffixed word ops) over valid/ready handshakes on both input and output. It replaces the fixed 64-bit mul/div pair inside the ALU with one shared datapath that has a configurable multiplier radix, early-out for special divide cases, output hold under backpressure, and pipeline flush.

---
 rtl/ysyx_22040750_muldiv_iter.sv | 217 +++++++++++++++++++++
 tb/tb_ysyx_22040750_muldiv_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_muldiv_iter.sv
// Shared iterative multiply/divide unit for the EX stage (RV64M/RV32M including word ops).
// Shift-add multiplier retiring MUL_BITS per cycle, restoring radix-2 divider, valid/ready on both sides.
module ysyx_22040750_muldiv_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 2
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [XLEN-1:0] I_op1,
    input  logic [XLEN-1:0] I_op2,
    input  logic [2:0]      I_func,
    input  logic            I_word,
    input  logic            I_flush,
    output logic            O_valid,
    input  logic            I_ready,
    output logic [XLEN-1:0] O_result,
    output logic            O_busy
);

    localparam int CW  = $clog2(XLEN + 1);
    localparam int WSH = XLEN - 32;
    localparam int MSH = $clog2(MUL_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]   a_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        func_q;
    logic              word_q;
    logic              neg_q;
    logic              rneg_q;
    logic              spec_q;
    logic [XLEN-1:0]   res_q;
    logic              valid_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] t;
        t = v << WSH;
        return t >>> WSH;
    endfunction

    assign O_ready  = (state_q == S_IDLE) && !I_rst;
    assign O_busy   = (state_q != S_IDLE);
    assign O_valid  = valid_q;
    assign O_result = res_q;

    logic accept;
    assign accept = I_valid && O_ready && !I_flush;

    // Operand preparation at accept
    logic            signed1, signed2, neg1, neg2;
    logic [XLEN-1:0] low32, op1_s, op2_s, op1_z, op2_z, mag1, mag2, minmag;
    logic [CW-1:0]   w_len;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        signed1  = (I_func == 3'd1) || (I_func == 3'd2) || (I_func == 3'd4) || (I_func == 3'd6);
        signed2  = (I_func == 3'd1) || (I_func == 3'd4) || (I_func == 3'd6);
        low32    = XLEN'(32'hFFFF_FFFF);
        op1_s    = I_word ? sext32(I_op1) : I_op1;
        op2_s    = I_word ? sext32(I_op2) : I_op2;
        op1_z    = I_word ? (I_op1 & low32) : I_op1;
        op2_z    = I_word ? (I_op2 & low32) : I_op2;
        neg1     = signed1 && op1_s[XLEN-1];
        neg2     = signed2 && op2_s[XLEN-1];
        mag1     = neg1 ? (~op1_s + XLEN'(1)) : op1_z;
        mag2     = neg2 ? (~op2_s + XLEN'(1)) : op2_z;
        minmag   = XLEN'(1) << (I_word ? 31 : XLEN - 1);
        w_len    = I_word ? CW'(32) : CW'(XLEN);
        div_zero = I_func[2] && (mag2 == '0);
        div_ovf  = I_func[2] && signed2 && neg1 && (mag1 == minmag) && (op2_s == '1);
        special  = div_zero || div_ovf;
        // Division by zero: q = all ones, r = dividend; overflow: q = dividend, r = 0
        if (I_func[1])
            spec_res = div_zero ? op1_s : '0;
        else
            spec_res = div_zero ? '1 : op1_s;
    end

    // Multiply step: acc = {partial high, remaining multiplier bits}
    logic [MUL_BITS-1:0]    mul_d;
    logic [XLEN+MUL_BITS-1:0] mul_sum;
    logic [2*XLEN-1:0]      mul_next, prod, prod_s;
    logic [XLEN-1:0]        mul_sel, mul_res;

    always_comb begin
        mul_d    = acc_q[MUL_BITS-1:0];
        mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                 + ({{MUL_BITS{1'b0}}, a_q} * {{XLEN{1'b0}}, mul_d});
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
        // A word product finishes WSH bits above the bottom of the accumulator
        prod     = mul_next >> (word_q ? WSH : 0);
        prod_s   = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
        if (func_q == 3'd0)
            mul_sel = prod_s[XLEN-1:0];
        else if (word_q)
            mul_sel = XLEN'(prod_s[63:32]);
        else
            mul_sel = prod_s[2*XLEN-1:XLEN];
        mul_res  = word_q ? sext32(mul_sel) : mul_sel;
    end

    // Divide step: acc = {partial remainder, dividend shifting out / quotient shifting in}
    logic [XLEN:0]   r_sh, diff;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin, div_sel, div_res;

    always_comb begin
        r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = r_sh - {1'b0, a_q};
        ge      = !diff[XLEN];
        rem_n   = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        quo_n   = {acc_q[XLEN-2:0], ge};
        q_fin   = neg_q ? (~quo_n + XLEN'(1)) : quo_n;
        r_fin   = rneg_q ? (~rem_n + XLEN'(1)) : rem_n;
        div_sel = func_q[1] ? r_fin : q_fin;
        div_res = word_q ? sext32(div_sel) : div_sel;
    end

    always_comb begin
        state_d = state_q;
        if (I_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = I_func[2] ? S_DIV : S_MUL;
                S_MUL:  if (cnt_q == CW'(1)) state_d = S_DONE;
                S_DIV:  if (cnt_q == CW'(1)) state_d = S_DONE;
                S_DONE: if (I_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            func_q  <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            spec_q  <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else if (I_flush) begin
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        func_q <= I_func;
                        word_q <= I_word;
                        neg_q  <= neg1 ^ neg2;
                        rneg_q <= neg1;
                        spec_q <= special;
                        a_q    <= I_func[2] ? mag2 : mag1;
                        if (!I_func[2]) begin
                            acc_q <= {{XLEN{1'b0}}, mag2};
                            cnt_q <= w_len >> MSH;
                        end else if (special) begin
                            // Special divides spend one DIV cycle so they finish at T+1
                            acc_q <= {{XLEN{1'b0}}, spec_res};
                            cnt_q <= CW'(1);
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, mag1 << (I_word ? WSH : 0)};
                            cnt_q <= w_len;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_q   <= mul_res;
                        valid_q <= 1'b1;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (spec_q) begin
                        res_q   <= acc_q[XLEN-1:0];
                        valid_q <= 1'b1;
                    end else begin
                        acc_q <= {rem_n, quo_n};
                        if (cnt_q == CW'(1)) begin
                            res_q   <= div_res;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (I_ready) valid_q <= 1'b0;
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_muldiv_iter.sv
// Directed bench for ysyx_22040750_muldiv_iter (XLEN=64, MUL_BITS=2) with hand-computed results.
module tb_ysyx_22040750_muldiv_iter;

    logic        I_sys_clk = 1'b0;
    logic        I_rst     = 1'b1;
    logic        I_valid   = 1'b0;
    logic        O_ready;
    logic [63:0] I_op1     = '0;
    logic [63:0] I_op2     = '0;
    logic [2:0]  I_func    = '0;
    logic        I_word    = 1'b0;
    logic        I_flush   = 1'b0;
    logic        O_valid;
    logic        I_ready   = 1'b0;
    logic [63:0] O_result;
    logic        O_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    ysyx_22040750_muldiv_iter #(.XLEN(64), .MUL_BITS(2)) dut (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .I_valid   (I_valid),
        .O_ready   (O_ready),
        .I_op1     (I_op1),
        .I_op2     (I_op2),
        .I_func    (I_func),
        .I_word    (I_word),
        .I_flush   (I_flush),
        .O_valid   (O_valid),
        .I_ready   (I_ready),
        .O_result  (O_result),
        .O_busy    (O_busy)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    // Present a request, measure latency to O_valid, check result, then consume it.
    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int lat, input logic [63:0] exp);
        int n;
        I_valid = 1'b1; I_func = f; I_word = w; I_op1 = a; I_op2 = b;
        tick();
        I_valid = 1'b0;
        n = 0;
        while (!O_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, O_result, exp);
        I_ready = 1'b1;
        tick();
        I_ready = 1'b0;
        check({tag, " drain"}, {62'd0, O_valid, O_ready}, 64'b01);
    endtask

    initial begin
        int  n;
        logic seen;

        // Reset
        repeat (3) tick();
        check("reset outputs", {60'd0, O_ready, O_valid, O_busy, 1'b0}, 64'd0);
        check("reset result", O_result, 64'd0);
        I_rst = 1'b0;
        #1;
        check("ready after reset", {63'd0, O_ready}, 64'd1);

        // Multiply
        run_op("MUL 7*-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 32, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("MULHU ones*ones", 3'd3, 1'b0, ONES, ONES, 32, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("MULHSU -1*2", 3'd2, 1'b0, ONES, 64'd2, 32, ONES);
        run_op("MULH 2^62*4", 3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 32, 64'd1);

        // Divide
        run_op("DIV -7/2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("REM -7/2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64, ONES);
        run_op("DIVU 100/7", 3'd5, 1'b0, 64'd100, 64'd7, 64, 64'd14);
        run_op("REMU 100/7", 3'd7, 1'b0, 64'd100, 64'd7, 64, 64'd2);

        // Special cases
        run_op("DIVU 5/0", 3'd5, 1'b0, 64'd5, 64'd0, 1, ONES);
        run_op("REM 5/0", 3'd6, 1'b0, 64'd5, 64'd0, 1, 64'd5);
        run_op("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000);
        run_op("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'd0);

        // Word ops
        run_op("DIVUW", 3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 32, 64'hFFFF_FFFF_8000_0000);
        run_op("MULW", 3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd2, 16, 64'd6);
        run_op("REMW", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 32, ONES);

        // Backpressure
        I_valid = 1'b1; I_func = 3'd0; I_word = 1'b0; I_op1 = 64'd7; I_op2 = 64'd6;
        tick();
        I_valid = 1'b0;
        n = 0;
        while (!O_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp latency", 64'(n), 64'd32);
        for (int i = 0; i < 5; i++) begin
            check("bp hold result", O_result, 64'd42);
            check("bp hold flags", {61'd0, O_valid, O_ready, O_busy}, 64'b101);
            tick();
        end
        I_ready = 1'b1;
        I_valid = 1'b1; I_func = 3'd5; I_op1 = 64'd100; I_op2 = 64'd7;
        tick();
        I_ready = 1'b0;
        check("bp release", {61'd0, O_valid, O_ready, O_busy}, 64'b010);
        tick();
        I_valid = 1'b0;
        check("bp next accepted", {62'd0, O_ready, O_busy}, 64'b01);
        n = 0;
        while (!O_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp next latency", 64'(n), 64'd64);
        check("bp next result", O_result, 64'd14);
        I_ready = 1'b1;
        tick();
        I_ready = 1'b0;

        // Flush mid-divide
        I_valid = 1'b1; I_func = 3'd4; I_op1 = 64'd100; I_op2 = 64'd7;
        tick();
        I_valid = 1'b0;
        repeat (9) tick();
        I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
        check("flush div", {61'd0, O_valid, O_ready, O_busy}, 64'b010);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen = seen | O_valid;
            tick();
        end
        check("flush no valid", {63'd0, seen}, 64'd0);
        run_op("MUL after flush", 3'd0, 1'b0, 64'd5, 64'd9, 32, 64'd45);

        // Request presented together with flush is dropped
        I_valid = 1'b1; I_flush = 1'b1; I_func = 3'd0;
        tick();
        I_valid = 1'b0; I_flush = 1'b0;
        check("flush blocks accept", {62'd0, O_ready, O_busy}, 64'b10);

        // Flush in DONE
        I_valid = 1'b1; I_func = 3'd5; I_op1 = 64'd5; I_op2 = 64'd0;
        tick();
        I_valid = 1'b0;
        tick();
        check("done before flush", {63'd0, O_valid}, 64'd1);
        I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
        check("flush done", {62'd0, O_valid, O_ready}, 64'b01);

        // Reset mid-multiply
        I_valid = 1'b1; I_func = 3'd0; I_op1 = 64'd7; I_op2 = 64'd6;
        tick();
        I_valid = 1'b0;
        repeat (5) tick();
        I_rst = 1'b1;
        tick();
        check("rst mid-mul flags", {61'd0, O_valid, O_ready, O_busy}, 64'b000);
        check("rst mid-mul result", O_result, 64'd0);
        I_rst = 1'b0;
        #1;
        check("ready after rst", {63'd0, O_ready}, 64'd1);
        run_op("REMU after rst", 3'd7, 1'b0, 64'd100, 64'd7, 64, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
